// File: rtl/nested_fsm_pkg.sv
// Shared types and code tables for the nested parent/child colour controller.
package nested_fsm_pkg;

    typedef enum logic [1:0] {
        BLUE = 2'd0,
        RED  = 2'd1,
        SUB  = 2'd2
    } parent_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUE  = 2'd1,
        SAT  = 2'd2,
        VAL  = 2'd3
    } child_t;

    localparam logic [1:0] CMD_EXIT   = 2'd0;
    localparam logic [1:0] CMD_TOGGLE = 2'd1;
    localparam logic [1:0] CMD_ENTER  = 2'd2;
    localparam logic [1:0] CMD_STEP   = 2'd3;

    localparam logic [1:0] OUT_BLUE = 2'd1;
    localparam logic [1:0] OUT_RED  = 2'd2;
    localparam logic [1:0] OUT_IDLE = 2'd2;
    localparam logic [1:0] OUT_HUE  = 2'd3;
    localparam logic [1:0] OUT_SAT  = 2'd1;
    localparam logic [1:0] OUT_VAL  = 2'd0;

    function automatic logic [1:0] child_out_code(child_t c);
        logic [1:0] code;
        case (c)
            HUE:     code = OUT_HUE;
            SAT:     code = OUT_SAT;
            VAL:     code = OUT_VAL;
            default: code = OUT_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/nested_fsm_child.sv
// Child FSM hosted by the parent's SUB state: IDLE/HUE/SAT/VAL sequencer,
// history register and the inactivity counter that requests a forced exit.
module nested_fsm_child
    import nested_fsm_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int HISTORY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       active,
    input  logic       enter,
    input  logic       exit,
    input  logic       step,
    input  logic       valid,
    output child_t     child_state,
    output logic       expire,
    output logic [1:0] child_out
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    child_t           child;
    child_t           hist;
    logic [CNT_W-1:0] cnt;

    // A valid command of any code keeps the sub-mode alive, so only idle cycles expire.
    assign expire = (TIMEOUT != 0) && active && !valid && (cnt == CNT_W'(TIMEOUT - 1));

    // child_state is the value the child takes at the coming edge, so the
    // parent can register its outputs from it without an extra cycle.
    always_comb begin
        child_state = child;
        if (exit) begin
            child_state = IDLE;
        end else if (enter) begin
            child_state = (HISTORY != 0) ? hist : IDLE;
        end else if (active && valid && step) begin
            case (child)
                IDLE:    child_state = HUE;
                HUE:     child_state = SAT;
                SAT:     child_state = VAL;
                default: child_state = IDLE;
            endcase
        end
    end

    assign child_out = child_out_code(child_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            child <= IDLE;
            hist  <= IDLE;
            cnt   <= '0;
        end else begin
            child <= child_state;
            if (exit) begin
                hist <= child;
            end
            if (!active || valid || exit || (TIMEOUT == 0)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nested_fsm_ctrl.sv
// Hierarchical Moore controller: parent BLUE/RED/SUB with a child sequencer
// inside SUB, valid-qualified commands and registered outputs.
module nested_fsm_ctrl
    import nested_fsm_pkg::*;
#(
    parameter int IN_W    = 2,
    parameter int OUT_W   = 2,
    parameter int TIMEOUT = 15,
    parameter int HISTORY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out,
    output logic [2:0]       state,
    output logic             sub_active,
    output logic             timeout
);

    parent_t    parent;
    parent_t    parent_next;
    child_t     child_next;
    logic       expire;
    logic [1:0] child_out;
    logic [1:0] out_code;
    logic [2:0] state_next;

    logic cmd_exit;
    logic cmd_toggle;
    logic cmd_enter;
    logic cmd_step;
    logic enter_sub;
    logic leave_sub;
    logic parent_bad;

    // Codes wider than two bits never match, so anything above 3 is a no-op.
    assign cmd_exit   = in_valid && (in == IN_W'(CMD_EXIT));
    assign cmd_toggle = in_valid && (in == IN_W'(CMD_TOGGLE));
    assign cmd_enter  = in_valid && (in == IN_W'(CMD_ENTER));
    assign cmd_step   = (in == IN_W'(CMD_STEP));

    assign parent_bad = (parent != BLUE) && (parent != RED) && (parent != SUB);
    assign enter_sub  = (parent == RED) && cmd_enter;
    assign leave_sub  = ((parent == SUB) && (cmd_exit || expire)) || parent_bad;

    nested_fsm_child #(
        .TIMEOUT (TIMEOUT),
        .HISTORY (HISTORY)
    ) u_child (
        .clk         (clk),
        .rst         (rst),
        .active      (parent == SUB),
        .enter       (enter_sub),
        .exit        (leave_sub),
        .step        (cmd_step),
        .valid       (in_valid),
        .child_state (child_next),
        .expire      (expire),
        .child_out   (child_out)
    );

    always_comb begin
        parent_next = parent;
        case (parent)
            BLUE: begin
                if (cmd_toggle) parent_next = RED;
            end
            RED: begin
                if (cmd_toggle)     parent_next = BLUE;
                else if (cmd_enter) parent_next = SUB;
            end
            SUB: begin
                if (leave_sub) parent_next = RED;
            end
            default: parent_next = RED;
        endcase
    end

    always_comb begin
        out_code   = OUT_RED;
        state_next = {1'b0, parent_next};
        case (parent_next)
            BLUE: out_code = OUT_BLUE;
            SUB: begin
                out_code   = child_out;
                state_next = {1'b1, child_next};
            end
            default: out_code = OUT_RED;
        endcase
    end

    // Outputs are taken from the next state so a command shows one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parent     <= RED;
            out        <= OUT_W'(OUT_RED);
            state      <= 3'b001;
            sub_active <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            parent     <= parent_next;
            out        <= OUT_W'(out_code);
            state      <= state_next;
            sub_active <= (parent_next == SUB);
            timeout    <= expire;
        end
    end

endmodule

// File: tb/tb_nested_fsm_ctrl.sv
// Bench for nested_fsm_ctrl: two instances (no history / long timeout, and
// history / short timeout) checked every cycle against a behavioural model.
module tb_nested_fsm_ctrl;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in3      = 3'd0;

    logic [3:0] out_a;
    logic [2:0] state_a;
    logic       sub_a;
    logic       tout_a;
    logic [1:0] out_b;
    logic [2:0] state_b;
    logic       sub_b;
    logic       tout_b;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int m_mode [2];
    int m_child[2];
    int m_hist [2];
    int m_idle [2];
    int m_tout [2];

    always #5 clk = ~clk;

    nested_fsm_ctrl #(.IN_W(3), .OUT_W(4), .TIMEOUT(15), .HISTORY(0)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in         (in3),
        .in_valid   (in_valid),
        .out        (out_a),
        .state      (state_a),
        .sub_active (sub_a),
        .timeout    (tout_a)
    );

    nested_fsm_ctrl #(.IN_W(2), .OUT_W(2), .TIMEOUT(4), .HISTORY(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in         (in3[1:0]),
        .in_valid   (in_valid),
        .out        (out_b),
        .state      (state_b),
        .sub_active (sub_b),
        .timeout    (tout_b)
    );

    // Model modes: 0 BLUE, 1 RED, 2 SUB; child is a position 0..3 in the wrap sequence.
    function automatic int model_to(int i);
        return (i == 0) ? 15 : 4;
    endfunction

    function automatic int model_hist_on(int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic int exp_out(int i);
        int colour[4] = '{2, 3, 1, 0};
        if (m_mode[i] == 0) return 1;
        if (m_mode[i] == 1) return 2;
        return colour[m_child[i]];
    endfunction

    function automatic int exp_state(int i);
        return (m_mode[i] == 2) ? 4 + m_child[i] : m_mode[i];
    endfunction

    task automatic model_leave(int i);
        m_hist[i]  = m_child[i];
        m_child[i] = 0;
        m_mode[i]  = 1;
    endtask

    task automatic model_step(int i, bit v, int cmd);
        m_tout[i] = 0;
        if (m_mode[i] == 2) begin
            if (v && cmd == 0) begin
                model_leave(i);
            end else if (v) begin
                if (cmd == 3) m_child[i] = (m_child[i] + 1) % 4;
                m_idle[i] = 0;
            end else if (m_idle[i] + 1 == model_to(i)) begin
                model_leave(i);
                m_tout[i] = 1;
            end else begin
                m_idle[i] = m_idle[i] + 1;
            end
        end else if (m_mode[i] == 1) begin
            if (v && cmd == 1) begin
                m_mode[i] = 0;
            end else if (v && cmd == 2) begin
                m_mode[i]  = 2;
                m_child[i] = (model_hist_on(i) != 0) ? m_hist[i] : 0;
                m_idle[i]  = 0;
            end
        end else if (v && cmd == 1) begin
            m_mode[i] = 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i]  = 1;
                m_child[i] = 0;
                m_hist[i]  = 0;
                m_idle[i]  = 0;
                m_tout[i]  = 0;
            end
        end else begin
            model_step(0, in_valid, int'(in3));
            model_step(1, in_valid, int'(in3[1:0]));
        end
    end

    task automatic checkOutput(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(bit v, logic [2:0] c);
        in_valid = v;
        in3      = c;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("a.out",   int'(out_a),   exp_out(0));
            checkOutput("a.state", int'(state_a), exp_state(0));
            checkOutput("a.sub",   int'(sub_a),   (m_mode[0] == 2) ? 1 : 0);
            checkOutput("a.tout",  int'(tout_a),  m_tout[0]);
            checkOutput("b.out",   int'(out_b),   exp_out(1));
            checkOutput("b.state", int'(state_b), exp_state(1));
            checkOutput("b.sub",   int'(sub_b),   (m_mode[1] == 2) ? 1 : 0);
            checkOutput("b.tout",  int'(tout_b),  m_tout[1]);
        end
    end

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rst a.out",   int'(out_a),   2);
        checkOutput("rst a.state", int'(state_a), 1);
        checkOutput("rst a.sub",   int'(sub_a),   0);
        checkOutput("rst b.out",   int'(out_b),   2);
        checkOutput("rst b.tout",  int'(tout_b),  0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Toggle out of RED and back
        applyStimulus(1'b1, 3'd1);
        checkOutput("toggle a.out",   int'(out_a),   1);
        checkOutput("toggle a.state", int'(state_a), 0);
        applyStimulus(1'b1, 3'd1);
        checkOutput("toggle back b.out", int'(out_b), 2);

        // Enter SUB and step through the wrap
        applyStimulus(1'b1, 3'd2);
        checkOutput("enter a.out",   int'(out_a),   2);
        checkOutput("enter a.state", int'(state_a), 4);
        checkOutput("enter a.sub",   int'(sub_a),   1);
        applyStimulus(1'b1, 3'd3);
        checkOutput("step1 a.out", int'(out_a), 3);
        applyStimulus(1'b1, 3'd3);
        checkOutput("step2 a.out", int'(out_a), 1);
        applyStimulus(1'b1, 3'd3);
        checkOutput("step3 a.out", int'(out_a), 0);
        checkOutput("step3 b.state", int'(state_b), 7);
        applyStimulus(1'b1, 3'd3);
        checkOutput("wrap a.out", int'(out_a), 2);

        // History: park at SAT, exit, re-enter
        applyStimulus(1'b1, 3'd3);
        applyStimulus(1'b1, 3'd3);
        checkOutput("sat b.out", int'(out_b), 1);
        applyStimulus(1'b1, 3'd0);
        checkOutput("exit b.sub", int'(sub_b), 0);
        applyStimulus(1'b1, 3'd2);
        checkOutput("reenter a.out (no hist)", int'(out_a),   2);
        checkOutput("reenter b.out (hist)",    int'(out_b),   1);
        checkOutput("reenter b.state",         int'(state_b), 6);
        applyStimulus(1'b1, 3'd5);
        checkOutput("noop a.out", int'(out_a), 2);
        checkOutput("noop b.out", int'(out_b), 1);
        applyStimulus(1'b1, 3'd0);
        applyStimulus(1'b0, 3'd1);
        checkOutput("invalid toggle a.out", int'(out_a), 2);
        checkOutput("invalid toggle b.out", int'(out_b), 2);

        // Forced exit on B after four idle cycles
        applyStimulus(1'b1, 3'd2);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 3'd0);
        checkOutput("pre-expiry b.sub",  int'(sub_b),  1);
        checkOutput("pre-expiry b.tout", int'(tout_b), 0);
        applyStimulus(1'b0, 3'd0);
        checkOutput("expiry b.tout",  int'(tout_b),  1);
        checkOutput("expiry b.sub",   int'(sub_b),   0);
        checkOutput("expiry b.out",   int'(out_b),   2);
        checkOutput("expiry b.state", int'(state_b), 1);
        checkOutput("expiry a.sub",   int'(sub_a),   1);
        applyStimulus(1'b0, 3'd0);
        checkOutput("post-expiry b.tout", int'(tout_b), 0);

        // STEP on the third idle cycle restarts the count
        applyStimulus(1'b1, 3'd2);
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b1, 3'd3);
        checkOutput("restart b.out", int'(out_b), 0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 3'd0);
        checkOutput("restart held b.sub", int'(sub_b), 1);
        applyStimulus(1'b0, 3'd0);
        checkOutput("restart expiry b.tout", int'(tout_b), 1);

        // Valid EXIT on the would-be expiry cycle
        applyStimulus(1'b1, 3'd2);
        checkOutput("reenter val b.out", int'(out_b), 0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b1, 3'd0);
        checkOutput("exit-vs-expiry b.tout", int'(tout_b), 0);
        checkOutput("exit-vs-expiry b.sub",  int'(sub_b),  0);
        applyStimulus(1'b0, 3'd0);
        checkOutput("exit-vs-expiry next b.tout", int'(tout_b), 0);

        // Reset mid-SUB at SAT clears history
        applyStimulus(1'b1, 3'd2);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 3'd3);
        checkOutput("pre-reset b.out", int'(out_b), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst b.out", int'(out_b), 2);
        checkOutput("async rst b.sub", int'(sub_b), 0);
        checkOutput("async rst a.sub", int'(sub_a), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 3'd2);
        checkOutput("post-reset enter b.out",   int'(out_b),   2);
        checkOutput("post-reset enter b.state", int'(state_b), 4);

        // Long idle: A times out after fifteen cycles
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, 3'd0);
        checkOutput("long idle a.sub", int'(sub_a), 0);
        checkOutput("long idle a.out", int'(out_a), 2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
